// File: rtl/arb4_ctrl.sv
// Four-requester arbiter: fixed priority or round-robin, one-hot grant held until
// release, with a forced release once a grant has been held for MAX_HOLD cycles.
module arb4_ctrl #(
    parameter int MAX_HOLD = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_req,
    input  logic       i_done,
    input  logic       i_rr_en,
    output logic [3:0] o_gnt,
    output logic [1:0] o_gnt_id,
    output logic       o_gnt_valid,
    output logic       o_timeout
);

    // state    | meaning
    // ST_IDLE  | no grant; arbitrates whenever any request is pending
    // ST_GRANT | one requester owns the resource until done, drop or hold limit
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [0:0] r_state;
    logic [3:0] r_gnt;
    logic [1:0] r_gnt_id;
    logic       r_gnt_valid;
    logic       r_timeout;
    logic [1:0] r_last_id;
    logic [7:0] r_hold_cnt;

    logic [1:0] w_start;
    logic [1:0] w_idx;
    logic [1:0] w_winner;
    logic       w_found;
    logic       w_rel_normal;
    logic       w_rel_force;

    // Round-robin search descends from the slot below the last winner, so the
    // last winner is always considered last.
    always_comb begin
        w_start  = r_last_id - 2'd1;
        w_idx    = 2'd0;
        w_winner = 2'd0;
        w_found  = 1'b0;
        if (i_rr_en) begin
            for (int k = 0; k < 4; k++) begin
                w_idx = w_start - 2'(k);
                if (!w_found && i_req[w_idx]) begin
                    w_winner = w_idx;
                    w_found  = 1'b1;
                end
            end
        end else begin
            if (i_req[3])      w_winner = 2'd3;
            else if (i_req[2]) w_winner = 2'd2;
            else if (i_req[1]) w_winner = 2'd1;
            else               w_winner = 2'd0;
        end
    end

    assign w_rel_normal = i_done || !i_req[r_gnt_id];
    assign w_rel_force  = (r_hold_cnt == HOLD_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_gnt       <= 4'b0000;
            r_gnt_id    <= 2'd0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_last_id   <= 2'd0;
            r_hold_cnt  <= 8'd0;
        end else if (r_state == ST_IDLE) begin
            r_timeout <= 1'b0;
            if (|i_req) begin
                r_state     <= ST_GRANT;
                r_gnt       <= 4'b0001 << w_winner;
                r_gnt_id    <= w_winner;
                r_gnt_valid <= 1'b1;
                r_hold_cnt  <= 8'd0;
                r_last_id   <= w_winner;
            end
        end else begin
            if (w_rel_normal || w_rel_force) begin
                r_state     <= ST_IDLE;
                r_gnt       <= 4'b0000;
                r_gnt_valid <= 1'b0;
                r_timeout   <= !w_rel_normal;
            end else begin
                r_timeout  <= 1'b0;
                r_hold_cnt <= (r_hold_cnt == HOLD_LAST) ? r_hold_cnt : r_hold_cnt + 8'd1;
            end
        end
    end

    assign o_gnt       = r_gnt;
    assign o_gnt_id    = r_gnt_id;
    assign o_gnt_valid = r_gnt_valid;
    assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_arb4_ctrl.sv
// Bench for arb4_ctrl: directed scenarios with literal expectations, then random
// traffic compared every cycle against a behavioural model of the arbiter.
module tb_arb4_ctrl;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic       rr_en = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_checks = 0;
    int n_fail = 0;

    arb4_ctrl #(.MAX_HOLD(MAX_HOLD)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_done      (done),
        .i_rr_en     (rr_en),
        .o_gnt       (gnt),
        .o_gnt_id    (gnt_id),
        .o_gnt_valid (gnt_valid),
        .o_timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input bit rr, input int last);
        if (!rr) begin
            for (int i = 3; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (last + 4 - k) % 4;
                if (r[c]) return c;
            end
        end
        return -1;
    endfunction

    // Model: owner, number of cycles held so far, last winner, pending timeout flag
    bit         m_busy = 0;
    int         m_id = 0;
    int         m_held = 0;
    int         m_last = 0;
    bit         m_to = 0;
    logic [3:0] s_req;
    logic       s_done, s_rr, s_rst;

    always @(posedge clk) begin
        s_req = req; s_done = done; s_rr = rr_en; s_rst = rst_n;
        #1;
        if (!s_rst) begin
            m_busy = 0; m_id = 0; m_held = 0; m_last = 0; m_to = 0;
        end else if (!m_busy) begin
            m_to = 0;
            if (s_req != 4'b0000) begin
                m_id = pick(s_req, s_rr, m_last);
                m_last = m_id;
                m_busy = 1;
                m_held = 1;
            end
        end else if (s_done || !s_req[m_id]) begin
            m_busy = 0; m_to = 0;
        end else if (m_held == MAX_HOLD) begin
            m_busy = 0; m_to = 1;
        end else begin
            m_held++;
        end
        check("model_gnt", int'(gnt), m_busy ? (1 << m_id) : 0);
        check("model_gnt_id", int'(gnt_id), m_id);
        check("model_gnt_valid", int'(gnt_valid), int'(m_busy));
        check("model_timeout", int'(timeout), int'(m_to));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    int rr_exp[5] = '{3, 2, 1, 0, 3};
    int n;

    initial begin
        tick(); tick();
        rst_n = 1'b1;

        // Reset mid-grant, then round-robin from a fresh last_id
        req = 4'b0100; tick();
        check("t1_gnt_before_rst", int'(gnt), 4);
        rst_n = 1'b0; #1;
        check("t1_rst_gnt", int'(gnt), 0);
        check("t1_rst_valid", int'(gnt_valid), 0);
        check("t1_rst_id", int'(gnt_id), 0);
        check("t1_rst_timeout", int'(timeout), 0);
        tick();
        rst_n = 1'b1; req = 4'b1111; rr_en = 1'b1;
        tick();
        check("t1_rr_gnt", int'(gnt), 8);
        check("t1_rr_id", int'(gnt_id), 3);
        done = 1'b1; tick(); done = 1'b0; req = 4'b0000; tick();

        // Fixed-priority sweep
        rr_en = 1'b0;
        for (int r = 0; r < 16; r++) begin
            req = 4'(r); tick();
            if (r == 0) begin
                check("t2_idle_valid", int'(gnt_valid), 0);
            end else begin
                check("t2_valid", int'(gnt_valid), 1);
                check("t2_id", int'(gnt_id), (r >= 8) ? 3 : (r >= 4) ? 2 : (r >= 2) ? 1 : 0);
                tick();
                done = 1'b1; tick(); done = 1'b0;
                check("t2_release", int'(gnt_valid), 0);
            end
            req = 4'b0000; tick();
        end

        // Round-robin fairness from reset
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        rr_en = 1'b1; req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_rr_id", int'(gnt_id), rr_exp[i]);
            check("t3_rr_valid", int'(gnt_valid), 1);
            done = 1'b1; tick(); done = 1'b0;
            check("t3_idle_gap", int'(gnt), 0);
        end
        req = 4'b0000; tick();

        // Hold-limit timeout
        rr_en = 1'b0; req = 4'b0010; tick();
        n = 0;
        while (gnt == 4'b0010 && n < 20) begin
            n++; tick();
        end
        check("t4_hold_cycles", n, MAX_HOLD);
        check("t4_timeout_gnt", int'(gnt), 0);
        check("t4_timeout_pulse", int'(timeout), 1);
        tick();
        check("t4_timeout_clear", int'(timeout), 0);
        check("t4_regrant", int'(gnt), 2);
        req = 4'b0000; tick(); tick();

        // Owner drops its request
        req = 4'b0100; tick(); tick(); tick();
        req = 4'b1001; tick();
        check("t5_drop_gnt", int'(gnt), 0);
        check("t5_drop_timeout", int'(timeout), 0);
        tick();
        check("t5_next_id", int'(gnt_id), 3);
        done = 1'b1; tick(); done = 1'b0; req = 4'b0000; tick();

        // Mode switch during grant, then stray done in idle
        rr_en = 1'b0; req = 4'b1000; tick();
        rr_en = 1'b1; tick();
        check("t6_hold_gnt", int'(gnt), 8);
        req = 4'b1010; done = 1'b1; tick(); done = 1'b0;
        tick();
        check("t6_rr_id", int'(gnt_id), 1);
        done = 1'b1; tick(); done = 1'b0; req = 4'b0000; tick();
        done = 1'b1; tick(); done = 1'b0;
        check("t6_stray_gnt", int'(gnt), 0);
        check("t6_stray_id", int'(gnt_id), 1);
        check("t6_stray_timeout", int'(timeout), 0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 11) == 0) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) rr_en = 1'($urandom_range(0, 1));
        end
        rst_n = 1'b1; req = 4'b0000; done = 1'b0;
        tick(); tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arb4_ctrl.md
# arb4_ctrl

Four-requester arbiter that shares one downstream resource (the 4:2 priority-encoded datapath and anything it feeds) between requesters `req[3:0]`. It applies either fixed priority (bit 3 highest, matching the encoder's d3>d2>d1>d0 order) or round-robin, holds a one-hot grant until release, and enforces a maximum hold time. Grant index and valid flag follow the encoder's encoding, so downstream muxing is unchanged.

## Interface
- `MAX_HOLD`, 8: maximum cycles a grant may stay asserted. Legal range is 2..255.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  4  request vector; a requester holds its bit high until it is granted and finishes.
- `done`  in  1  one-cycle pulse from the granted requester or resource, ending the current grant.
- `rr_en`  in  1  1 = round-robin, 0 = fixed priority; sampled only at arbitration.
- `gnt`  out  4  one-hot grant; all zero when idle.
- `gnt_id`  out  2  binary index of the granted requester; holds its last value when idle.
- `gnt_valid`  out  1  high while any grant is active (equals `|gnt`).
- `timeout`  out  1  one-cycle pulse when a grant is revoked because `MAX_HOLD` was reached.

## Operation
- FSM has two states, IDLE and GRANT; all outputs are registered.
- **Reset** (async, `rst_n`=0): state=IDLE, `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `timeout`=0, `last_id`=0, `hold_cnt`=0.
- **IDLE, `req`=0:** stay in IDLE.
- **IDLE, `req`!=0:** arbitrate, then on the next edge go to GRANT with `gnt`=onehot(winner), `gnt_id`=winner, `gnt_valid`=1, `hold_cnt`=0, `last_id`=winner.
- **Fixed priority (`rr_en`=0):** winner is the highest set index (3>2>1>0).
- **Round-robin (`rr_en`=1):** search order starts at (`last_id`-1) mod 4 and descends, wrapping 0→3. The first set bit wins.
  - `last_id`=0 after reset, so the first round-robin search order is 3,2,1,0, the same as fixed priority.
  - The previous winner is searched last.
- **GRANT:** `hold_cnt` increments each cycle and saturates at `MAX_HOLD`-1. Release conditions, highest priority first:
  1. `done`=1, or `req[gnt_id]`=0: normal release; next state IDLE, `gnt`=0, `gnt_valid`=0.
  2. `hold_cnt`==`MAX_HOLD`-1 and neither condition above holds: forced release; next state IDLE, `gnt`=0, `timeout`=1 for one cycle.
  3. Otherwise stay in GRANT.
- `done` seen in IDLE is ignored.
- Changes to `req` bits other than `gnt_id` during GRANT are ignored.
- `rr_en` changing during GRANT has no effect until the next IDLE arbitration.
- `last_id` updates only on a grant and is kept in both modes. Switching to round-robin continues from the last winner.
- `hold_cnt` width is 8 bits. Compare against `MAX_HOLD`-1 as an unsigned value.

## Timing
- **Request-to-grant latency:** 1 cycle. `req` high at the edge ending an IDLE cycle → `gnt` high after that edge.
- **Minimum grant length:** 1 cycle (`done` in the first GRANT cycle).
- **Maximum grant length:** `MAX_HOLD` cycles.
- **Turnaround:** every release is followed by at least one IDLE cycle with `gnt`=0. Back-to-back grants are therefore spaced by exactly one idle cycle.
- **Timeout pulse:** asserted in the first IDLE cycle after a forced release. It coincides with `gnt`=0 and is never high with `gnt_valid`=1.
- **Done-to-release:** `done` sampled at edge N → `gnt`=0 after edge N.
- **Reset mid-grant:** `gnt` drops immediately and asynchronously. Arbitration resumes on the first edge after `rst_n` rises, with `last_id`=0.
- **Invariants:** `gnt` is always one-hot or zero; `gnt_valid`==(`gnt`!=0); `gnt[gnt_id]`==1 whenever `gnt_valid`=1.

## Test plan
1. **Reset values:** assert `rst_n`=0 mid-grant (`gnt`=4'b0100) → all outputs 0 immediately. After release, `req`=4'b1111 with `rr_en`=1 → `gnt`=4'b1000, `gnt_id`=3.
2. **Fixed-priority sweep:** apply `req`=0..15 with `rr_en`=0, and `done` pulsed 2 cycles after each grant. Expected `gnt_id`/`gnt_valid`:
   - `req`=0 → `gnt_valid` stays 0.
   - `req`=1 → 0; `req`=2..3 → 1; `req`=4..7 → 2; `req`=8..15 → 3.
3. **Round-robin fairness:** hold `req`=4'b1111 with `rr_en`=1 and pulse `done` every grant → `gnt_id` sequence 3,2,1,0,3, with exactly one idle cycle between grants.
4. **Timeout:** `MAX_HOLD`=8, `req`=4'b0010 held, no `done` → `gnt`=4'b0010 for exactly 8 cycles, then `gnt`=0 with `timeout`=1 for 1 cycle, then re-grant to 1 one cycle later.
5. **Requester drop:** grant to 2 (`req`=4'b0100), then at cycle 3 drive `req`=4'b1001 → release on the next edge with `timeout`=0. After one idle cycle, `gnt_id`=3 (fixed priority).
6. **Mode switch and stray `done`:**
   - Toggle `rr_en` 0→1 during a grant to 3 → the current grant is unaffected; with `req`=4'b1010 the next arbitration picks 1.
   - A `done` pulse in IDLE causes no output change.
